// File: rtl/zd_serdes_pkg.sv
// Shared types and constants for the zd lane serializer slice.
// Optional feature macro used by this slice: ZD_SER_XZ_STATS_EN (adds xz_count output).
package zd_serdes_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } ser_state_e;

    localparam int unsigned ZD_LANES = 3;
    localparam int unsigned ZD_WIDTH = 20;

    typedef logic [15:0] xz_count_t;

    // Lane index width; a single-lane build still needs a 1-bit index port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xz_scrub.sv
// Combinational 4-state to 2-state word scrubber: only a definite 1 survives,
// and any X/Z bit in the source word raises has_xz.
module xz_scrub #(
    parameter int unsigned WIDTH = 20
) (
    input  logic [WIDTH-1:0] word,
    output bit   [WIDTH-1:0] data,
    output bit               has_xz
);

    // Per-bit scrub and unknown-bit reduction.
    always_comb begin
        data   = '0;
        has_xz = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            data[b] = (word[b] === 1'b1);
            if ((word[b] !== 1'b0) && (word[b] !== 1'b1)) begin
                has_xz = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zd_lane_serializer.sv
// Captures LANES 4-state words in one handshake and streams them out one per
// handshake as scrubbed 2-state words, flagging words that carried X/Z.
// Optional macro: ZD_SER_XZ_STATS_EN adds a saturating 16-bit xz_count output.
module zd_lane_serializer
    import zd_serdes_pkg::*;
#(
    parameter int unsigned  LANES = ZD_LANES,
    parameter int unsigned  WIDTH = ZD_WIDTH,
    localparam int unsigned IdxW  = idx_width(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data [LANES],
    output logic             out_valid,
    input  logic             out_ready,
    output bit   [WIDTH-1:0] out_data,
    output logic [IdxW-1:0]  out_idx,
    output logic             out_last,
    output bit               out_xz
`ifdef ZD_SER_XZ_STATS_EN
    ,
    output xz_count_t        xz_count
`endif
);

    ser_state_e       state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [IdxW-1:0]  idx_q;
    logic             last_q;
    logic [WIDTH-1:0] lane_buf_q [LANES];

    logic             in_valid_ok;
    logic             out_ready_ok;
    logic [WIDTH-1:0] sel_word;
    bit   [WIDTH-1:0] scrub_data;
    bit               scrub_xz;

    // Unknown handshake inputs must never start a transfer.
    assign in_valid_ok  = (in_valid === 1'b1);
    assign out_ready_ok = (out_ready === 1'b1);

    // Capture/stream FSM with registered handshake and index outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_ok) begin
                        lane_buf_q  <= in_data;
                        state_q     <= SEND;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                        last_q      <= (LANES == 1);
                    end
                end
                SEND: begin
                    if (out_ready_ok) begin
                        if (last_q) begin
                            state_q     <= IDLE;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            idx_q       <= '0;
                            last_q      <= 1'b0;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            last_q <= ((idx_q + 1'b1) == IdxW'(LANES - 1));
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    idx_q       <= '0;
                    last_q      <= 1'b0;
                end
            endcase
        end
    end

    assign sel_word = lane_buf_q[idx_q];

    xz_scrub #(
        .WIDTH(WIDTH)
    ) u_scrub (
        .word   (sel_word),
        .data   (scrub_data),
        .has_xz (scrub_xz)
    );

    // Data outputs read zero whenever no word is being offered.
    always_comb begin
        out_data = '0;
        out_xz   = 1'b0;
        if (out_valid_q) begin
            out_data = scrub_data;
            out_xz   = scrub_xz;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

`ifdef ZD_SER_XZ_STATS_EN
    xz_count_t xz_count_q;

    // Count X/Z-bearing words as they are handed off, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xz_count_q <= '0;
        end else if (out_valid_q && out_ready_ok && scrub_xz && (xz_count_q != 16'hFFFF)) begin
            xz_count_q <= xz_count_q + 16'd1;
        end
    end

    assign xz_count = xz_count_q;
`endif

endmodule

// File: tb/tb_zd_lane_serializer.sv
// Directed self-checking bench for zd_lane_serializer (LANES=3, WIDTH=20).
// Also exercises xz_count when built with ZD_SER_XZ_STATS_EN.
module tb_zd_lane_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data [3];
    logic        out_valid;
    logic        out_ready;
    bit   [19:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    bit          out_xz;
`ifdef ZD_SER_XZ_STATS_EN
    logic [15:0] xz_count;
    logic [15:0] exp_cnt;
`endif

    int checks;
    int fails;

    zd_lane_serializer #(
        .LANES(3),
        .WIDTH(20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_xz    (out_xz)
`ifdef ZD_SER_XZ_STATS_EN
        ,
        .xz_count  (xz_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference scrub: a bit is 1 only where the stimulus bit is a definite 1.
    function automatic logic [19:0] scrub_ref(input logic [19:0] w);
        logic [19:0] r;
        for (int b = 0; b < 20; b++) begin
            r[b] = (w[b] === 1'b1);
        end
        return r;
    endfunction

    // Advance one clock, ending on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Status tuple: {out_valid, in_ready, out_idx, out_last, out_xz, out_data}.
    task automatic test_reset();
        logic [25:0] got;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = '{20'h12345, 20'h23456, 20'h34567};
        repeat (3) @(negedge clk);
        got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
        checks++;
        if (got !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0}) begin
            fails++;
            $display("FAIL reset_hold: got %h want %h", got, {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0});
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
        checks++;
        if (got !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0}) begin
            fails++;
            $display("FAIL reset_idle: got %h want %h", got, {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0});
        end
`ifdef ZD_SER_XZ_STATS_EN
        exp_cnt = 16'h0;
        checks++;
        if (xz_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_xz_count: got %h want 0000", xz_count);
        end
`endif
    endtask

    task automatic test_clean();
        logic [19:0] exp_w [3];
        logic [25:0] got;
        logic [25:0] want;
        exp_w     = '{20'h00001, 20'hABCDE, 20'hFFFFF};
        in_data   = '{20'h00001, 20'hABCDE, 20'hFFFFF};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got  = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
            want = {1'b1, 1'b0, 2'(i), (i == 2), 1'b0, exp_w[i]};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL clean_word%0d: got %h want %h", i, got, want);
            end
            step();
        end
        got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
        checks++;
        if (got !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0}) begin
            fails++;
            $display("FAIL clean_idle: got %h want %h", got, {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0});
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] got;
        logic [25:0] want;
        in_data   = '{20'h11111, 20'hABCDE, 20'h22222};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 20'h11111}) begin
            fails++;
            $display("FAIL bp_word0: got %h want %h", got, {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 20'h11111});
        end
        step();
        out_ready = 1'b0;
        want = {1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 20'hABCDE};
        for (int k = 0; k < 5; k++) begin
            // Upstream churn while stalled must not leak into the held word.
            in_data  = '{20'(k * 20'h13579), 20'h55555 ^ 20'(k), 20'h0F0F0};
            in_valid = 1'b1;
            got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL bp_hold%0d: got %h want %h", k, got, want);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL bp_release: got %h want %h", got, want);
        end
        step();
        got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
        checks++;
        if (got !== {1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 20'h22222}) begin
            fails++;
            $display("FAIL bp_word2: got %h want %h", got, {1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 20'h22222});
        end
        step();
        got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
        checks++;
        if (got !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0}) begin
            fails++;
            $display("FAIL bp_idle: got %h want %h", got, {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0});
        end
    endtask

    task automatic test_xz_scrub();
        logic [19:0] sx [3];
        logic [19:0] exp_d;
        logic        exp_x;
        logic [25:0] got;
        logic [25:0] want;
        // Word 0 scrubs to 20'h8F000 with the X/Z flag set on a 4-state simulator.
        sx[0] = 20'b1x0z_1111_0000_zzzz_xxxx;
        sx[1] = 20'h12345;
        sx[2] = {16'hFFFF, 4'b01xz};
        in_data   = sx;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_d = scrub_ref(sx[i]);
            exp_x = $isunknown(sx[i]);
            got   = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
            want  = {1'b1, 1'b0, 2'(i), (i == 2), exp_x, exp_d};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL xz_word%0d: got %h want %h", i, got, want);
            end
`ifdef ZD_SER_XZ_STATS_EN
            checks++;
            if (xz_count !== exp_cnt) begin
                fails++;
                $display("FAIL xz_count_w%0d: got %h want %h", i, xz_count, exp_cnt);
            end
            if (exp_x && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
`endif
            step();
        end
`ifdef ZD_SER_XZ_STATS_EN
        checks++;
        if (xz_count !== exp_cnt) begin
            fails++;
            $display("FAIL xz_count_end: got %h want %h", xz_count, exp_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [19:0] va [3];
        logic [19:0] vb [3];
        logic [25:0] got;
        logic [25:0] want;
        va = '{20'hA0001, 20'hA0002, 20'hA0003};
        vb = '{20'hB0001, 20'hB0002, 20'hB0003};
        in_data   = va;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got  = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
            want = {1'b1, 1'b0, 2'(i), (i == 2), 1'b0, va[i]};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL b2b_a%0d: got %h want %h", i, got, want);
            end
            step();
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        // Accept the next vector on the first edge after the last handshake.
        in_data  = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got  = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
            want = {1'b1, 1'b0, 2'(i), (i == 2), 1'b0, vb[i]};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL b2b_b%0d: got %h want %h", i, got, want);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_send();
        logic [25:0] got;
        in_data   = '{20'h33333, 20'h44444, 20'h55555};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
        checks++;
        if (got !== {1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 20'h44444}) begin
            fails++;
            $display("FAIL mid_pre: got %h want %h", got, {1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 20'h44444});
        end
        rst_n = 1'b0;
        #1;
        got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
        checks++;
        if (got !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0}) begin
            fails++;
            $display("FAIL mid_async: got %h want %h", got, {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0});
        end
`ifdef ZD_SER_XZ_STATS_EN
        exp_cnt = 16'h0;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            got = {out_valid, in_ready, out_idx, out_last, out_xz, out_data};
            checks++;
            if (got !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0}) begin
                fails++;
                $display("FAIL mid_nostale%0d: got %h want %h", k, got,
                         {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20'h0});
            end
        end
    endtask

`ifdef ZD_SER_XZ_STATS_EN
    task automatic test_saturation();
        logic [19:0] sx [3];
        sx[0] = 20'hx0000;
        sx[1] = 20'h0z000;
        sx[2] = 20'h000x1;
        force dut.xz_count_q = 16'hFFFE;
        #1;
        release dut.xz_count_q;
        exp_cnt   = 16'hFFFE;
        in_data   = sx;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ($isunknown(sx[i]) && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
            step();
        end
        checks++;
        if (xz_count !== exp_cnt) begin
            fails++;
            $display("FAIL sat_count: got %h want %h", xz_count, exp_cnt);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '{20'h0, 20'h0, 20'h0};
        @(negedge clk);
        test_reset();
        test_clean();
        test_backpressure();
        test_xz_scrub();
        test_back_to_back();
        test_reset_mid_send();
`ifdef ZD_SER_XZ_STATS_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
